// File: rtl/tdc_hit_controller.sv
// Hit sequencing controller for the CARRY4 TDC delay line: arm, capture, encode, handshake, dead time.
// Optional TDC_BUBBLE_FILTER_EN: fine code = population count of the snapshot instead of leading-ones run.
module tdc_hit_controller #(
    parameter int NCARRY4     = 48,
    parameter int COARSE_W    = 24,
    parameter int FINE_W      = 8,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [4*NCARRY4-1:0]       co_i,
    output logic                       arm_o,
    output logic                       ts_valid,
    input  logic                       ts_ready,
    output logic [COARSE_W+FINE_W-1:0] ts_data,
    output logic                       ts_ovf,
    output logic                       busy
);

    localparam int N = 4 * NCARRY4;
    localparam logic [7:0]          DEAD_LOAD  = 8'(DEAD_CYCLES);
    localparam logic [FINE_W-1:0]   FINE_ONE   = {{(FINE_W-1){1'b0}}, 1'b1};
    localparam logic [COARSE_W-1:0] COARSE_ONE = {{(COARSE_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ARMED  = 3'd2,
        ST_ENCODE = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    state_t              state_r;
    logic [N-1:0]        code_r;
    logic [N-1:0]        snap_r;
    logic [COARSE_W-1:0] coarse_cnt_r;
    logic [COARSE_W-1:0] coarse_snap_r;
    logic [7:0]          dead_cnt_r;
    logic [FINE_W-1:0]   fine_s;

`ifdef TDC_BUBBLE_FILTER_EN
    function automatic logic [FINE_W-1:0] encode_fine(input logic [N-1:0] v);
        logic [FINE_W-1:0] cnt;
        cnt = {FINE_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                cnt = cnt + FINE_ONE;
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction
`else
    // Length of the unbroken run of ones starting at tap 0.
    function automatic logic [FINE_W-1:0] encode_fine(input logic [N-1:0] v);
        logic [FINE_W-1:0] cnt;
        logic              run;
        cnt = {FINE_W{1'b0}};
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && v[i]) begin
                cnt = cnt + FINE_ONE;
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction
`endif

    // Fine code derived from the frozen snapshot.
    always_comb begin
        fine_s = encode_fine(snap_r);
    end

    // Tap capture register; co_i is asynchronous and is only used after this stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r <= {N{1'b0}};
        end else begin
            code_r <= co_i;
        end
    end

    // Free-running coarse time base, advancing only while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            coarse_cnt_r <= {COARSE_W{1'b0}};
        end else if (enable) begin
            coarse_cnt_r <= coarse_cnt_r + COARSE_ONE;
        end else begin
            coarse_cnt_r <= coarse_cnt_r;
        end
    end

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            arm_o         <= 1'b0;
            ts_valid      <= 1'b0;
            ts_data       <= {(COARSE_W+FINE_W){1'b0}};
            ts_ovf        <= 1'b0;
            busy          <= 1'b0;
            dead_cnt_r    <= 8'd0;
            snap_r        <= {N{1'b0}};
            coarse_snap_r <= {COARSE_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r    <= ST_CLEAR;
                        dead_cnt_r <= DEAD_LOAD;
                        busy       <= 1'b1;
                    end else begin
                        busy       <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (dead_cnt_r != 8'd0) begin
                        dead_cnt_r <= dead_cnt_r - 8'd1;
                    end else begin
                        dead_cnt_r <= 8'd0;
                    end
                    // Re-arm only once the dead time has expired and the line has drained.
                    if (!enable) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if ((dead_cnt_r == 8'd0) && (code_r == {N{1'b0}})) begin
                        state_r <= ST_ARMED;
                        arm_o   <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                    end
                end
                ST_ARMED: begin
                    if (code_r[0]) begin
                        state_r       <= ST_ENCODE;
                        snap_r        <= code_r;
                        coarse_snap_r <= coarse_cnt_r;
                        arm_o         <= 1'b0;
                    end else if (!enable) begin
                        state_r <= ST_IDLE;
                        arm_o   <= 1'b0;
                        busy    <= 1'b0;
                    end else begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_ENCODE: begin
                    ts_data  <= {coarse_snap_r, fine_s};
                    ts_ovf   <= &snap_r;
                    ts_valid <= 1'b1;
                    state_r  <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (ts_ready) begin
                        ts_valid   <= 1'b0;
                        state_r    <= ST_CLEAR;
                        dead_cnt_r <= DEAD_LOAD;
                    end else begin
                        state_r    <= ST_OUTPUT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    arm_o    <= 1'b0;
                    ts_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
